// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the instruction encoder/loader and the immediate generator.
// Provides field widths, the R-type opcode set, the I-type classifier and the loader FSM states.
package cpu_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned INSTR_W = 16;

  // Register-register opcodes; every other opcode carries an 8-bit immediate.
  localparam logic [OPC_W-1:0] OPC_R_A = 4'hA;
  localparam logic [OPC_W-1:0] OPC_R_B = 4'hB;
  localparam logic [OPC_W-1:0] OPC_R_D = 4'hD;
  localparam logic [OPC_W-1:0] OPC_R_F = 4'hF;

  function automatic logic is_itype(input logic [OPC_W-1:0] opcode);
    return !(opcode inside {OPC_R_A, OPC_R_B, OPC_R_D, OPC_R_F});
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } load_state_e;

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO for encoded {address, data} words.
// Ports: clk, reset (async, active-high), push/push_data, pop, head (oldest entry), full, empty.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module enc_fifo2 #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    empty   = (cnt_q == 2'd0);
    full    = (cnt_q == 2'd2);
    do_pop  = pop & !empty;
    do_push = push & (!full | do_pop);
    head    = mem_q[rd_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Encodes decoded instruction fields into 16-bit words and writes them to consecutive
// instruction-memory addresses through a 2-entry FIFO.
// Ports: clk, reset (async, active-high); start/base_addr begin a program load;
// in_valid/in_ready/in_last + opcode/rd/rs/rt/imm form the field stream;
// mem_we/mem_ready/mem_addr/mem_wdata form the memory write port;
// busy, done, err_imm, err_overflow and instr_count report status.
module instruction_encoder_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        opcode,
  input  logic [3:0]        rd,
  input  logic [3:0]        rs,
  input  logic [3:0]        rt,
  input  logic [15:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_imm,
  output logic              err_overflow,
  output logic [ADDR_W:0]   instr_count
);

  localparam int unsigned FifoW = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] acc_ptr_q;
  logic              acc_end_q;
  logic              err_imm_q;
  logic              err_overflow_q;
  logic [ADDR_W:0]   instr_count_q;

  logic               itype;
  logic               imm_bad;
  logic [INSTR_W-1:0] enc_word;
  logic               accept;
  logic               pop;
  logic               overflow;
  logic               start_load;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FifoW-1:0]   fifo_head;

  // Encoder: immediate is truncated to 8 bits even when it does not fit.
  always_comb begin
    itype    = is_itype(opcode);
    imm_bad  = itype & (imm[15:8] != {8{imm[7]}});
    enc_word = itype ? {opcode, rd, imm[7:0]} : {opcode, rd, rs, rt};
  end

  always_comb begin
    in_ready   = (state_q == StLoad) & !fifo_full & !acc_end_q;
    accept     = in_valid & in_ready;
    overflow   = (state_q == StLoad) & in_valid & acc_end_q;
    start_load = (state_q == StIdle) & start;
    mem_we     = !fifo_empty;
    pop        = mem_we & mem_ready;
    mem_addr   = fifo_head[FifoW-1 -: ADDR_W];
    mem_wdata  = fifo_head[INSTR_W-1:0];
  end

  enc_fifo2 #(
    .W(FifoW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .push_data({acc_ptr_q, enc_word}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if ((accept && in_last) || overflow) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_ptr_q      <= '0;
      acc_end_q      <= 1'b0;
      err_imm_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      instr_count_q  <= '0;
    end else if (start_load) begin
      acc_ptr_q      <= base_addr;
      acc_end_q      <= 1'b0;
      err_imm_q      <= 1'b0;
      err_overflow_q <= 1'b0;
      instr_count_q  <= '0;
    end else begin
      if (accept) begin
        // The last address is usable once; after that the pointer stops rather than wrapping.
        if (acc_ptr_q == LastAddr) begin
          acc_end_q <= 1'b1;
        end else begin
          acc_ptr_q <= acc_ptr_q + 1'b1;
        end
        if (imm_bad) err_imm_q <= 1'b1;
      end
      if (overflow) err_overflow_q <= 1'b1;
      if (pop) instr_count_q <= instr_count_q + 1'b1;
    end
  end

  always_comb begin
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    err_imm      = err_imm_q;
    err_overflow = err_overflow_q;
    instr_count  = instr_count_q;
  end

endmodule
